// File: rtl/timer_if.sv
// CPU-side register bus for the timer: one select, word address, byte strobes,
// a one-cycle ready acknowledge, plus the level interrupt back to the CPU.
interface timer_if;
    logic        sel;
    logic [2:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport master (output sel, addr, wstrb, wdata, input rdata, ready, irq);
    modport slave  (input sel, addr, wstrb, wdata, output rdata, ready, irq);
endinterface

// File: rtl/timer.sv
// Prescaled 32-bit down-counting timer with one-shot / auto-reload modes,
// sticky expiry flag and maskable level interrupt, on a simple 2-cycle bus.
module timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic   clk,
    input  logic   rst,
    timer_if.slave bus
);
    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_PRE  = 3'd1;
    localparam logic [2:0] A_CNT  = 3'd2;
    localparam logic [2:0] A_RLD  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;

    logic                  en, auto_rl, ie, exp_flag;
    logic [PRESCALE_W-1:0] prescale, pc;
    logic [31:0]           count, reload, rd_val, pre_merged;
    logic                  access, wr, tick, expire;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    // An access starts only while ready is low, so a held sel alternates ready.
    assign access     = bus.sel && !bus.ready;
    assign wr         = access && (bus.wstrb != 4'b0000);
    assign tick       = en && (pc == prescale);
    assign expire     = tick && (count == 32'd0);
    assign pre_merged = merge(32'(prescale), bus.wdata, bus.wstrb);
    assign bus.irq    = exp_flag && ie;

    always_comb begin
        rd_val = 32'd0;
        case (bus.addr)
            A_CTRL:  rd_val = {29'd0, ie, auto_rl, en};
            A_PRE:   rd_val = 32'(prescale);
            A_CNT:   rd_val = count;
            A_RLD:   rd_val = reload;
            A_STAT:  rd_val = {31'd0, exp_flag};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b0;
            auto_rl   <= 1'b0;
            ie        <= 1'b0;
            exp_flag  <= 1'b0;
            prescale  <= '0;
            pc        <= '0;
            count     <= 32'd0;
            reload    <= 32'd0;
            bus.ready <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            bus.ready <= access;
            if (access) bus.rdata <= rd_val;

            if (!en || tick || (wr && (bus.addr == A_CTRL || bus.addr == A_PRE)))
                pc <= '0;
            else
                pc <= pc + 1'b1;

            // A CPU write of EN overrides the one-shot auto-clear.
            if (wr && bus.addr == A_CTRL && bus.wstrb[0])
                {ie, auto_rl, en} <= bus.wdata[2:0];
            else if (expire && !auto_rl)
                en <= 1'b0;

            if (wr && bus.addr == A_PRE) prescale <= pre_merged[PRESCALE_W-1:0];
            if (wr && bus.addr == A_RLD) reload   <= merge(reload, bus.wdata, bus.wstrb);

            if (wr && bus.addr == A_CNT)
                count <= merge(count, bus.wdata, bus.wstrb);
            else if (tick) begin
                if (count != 32'd0) count <= count - 32'd1;
                else if (auto_rl)   count <= reload;
            end

            // Expiry beats a same-cycle write-1-to-clear.
            if (expire)
                exp_flag <= 1'b1;
            else if (wr && bus.addr == A_STAT && bus.wstrb[0] && bus.wdata[0])
                exp_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: register table, directed corner sequences and
// random bus traffic compared every cycle against a register-file level model.
module tb_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    timer_if bus();

    timer #(.PRESCALE_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: register file indexed by word address, plus cycles left to next tick.
    logic [31:0] m_reg [8];
    logic [31:0] m_rdata;
    logic        m_ready;
    int          m_wait;

    typedef struct {
        logic [2:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [22];

    function automatic logic [31:0] reg_mask(int a);
        case (a)
            0:       return 32'h0000_0007;
            1:       return 32'h0000_FFFF;
            2, 3:    return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(int a);
        case (a)
            0:       return 4'b0001;
            1:       return 4'b0011;
            2, 3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_rdata = 32'd0;
        m_ready = 1'b0;
        m_wait  = 0;
    endtask

    task automatic model_step();
        logic [31:0] old [8];
        logic [31:0] v;
        bit acc, wr, tick, expire;
        int a;
        old    = m_reg;
        a      = int'(bus.addr);
        acc    = bus.sel && !m_ready;
        wr     = acc && (bus.wstrb != 4'b0);
        tick   = old[0][0] && (m_wait == 0);
        expire = tick && (old[2] == 32'd0);
        m_ready = acc;
        if (acc) m_rdata = old[a];
        if (tick) begin
            if (old[2] != 0)   m_reg[2] = old[2] - 1;
            else if (old[0][1]) m_reg[2] = old[3];
            else               m_reg[0][0] = 1'b0;
        end
        if (wr && (bus.wstrb & byte_mask(a)) != 4'b0) begin
            v = old[a];
            for (int b = 0; b < 4; b++) if (bus.wstrb[b]) v[8*b +: 8] = bus.wdata[8*b +: 8];
            m_reg[a] = v & reg_mask(a);
        end
        if (wr && a == 4 && bus.wstrb[0] && bus.wdata[0]) m_reg[4] = 32'd0;
        if (expire) m_reg[4] = 32'd1;
        if (!old[0][0] || tick || (wr && (a == 0 || a == 1))) m_wait = int'(m_reg[1]);
        else m_wait--;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("ready", {31'd0, bus.ready}, {31'd0, m_ready});
        chk("irq",   {31'd0, bus.irq},   {31'd0, m_reg[4][0] & m_reg[0][2]});
        chk("rdata", bus.rdata, m_rdata);
    endtask

    task automatic acc(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd);
        bus.sel = 1'b1; bus.addr = a; bus.wstrb = s; bus.wdata = d;
        cyc();
        rd = bus.rdata;
        bus.sel = 1'b0; bus.wstrb = 4'b0;
        cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] dummy;
        acc(a, s, d, dummy);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        acc(a, 4'b0, 32'd0, v);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        bus.sel = 1'b0; bus.addr = 3'd0; bus.wstrb = 4'b0; bus.wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_irq",   {31'd0, bus.irq},   32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        // Register map, masking and strobes with the timer disabled.
        tbl[0]  = '{3'd0, 4'h0, 32'h0,          32'h0};
        tbl[1]  = '{3'd1, 4'h0, 32'h0,          32'h0};
        tbl[2]  = '{3'd2, 4'h0, 32'h0,          32'h0};
        tbl[3]  = '{3'd3, 4'h0, 32'h0,          32'h0};
        tbl[4]  = '{3'd4, 4'h0, 32'h0,          32'h0};
        tbl[5]  = '{3'd7, 4'h0, 32'h0,          32'h0};
        tbl[6]  = '{3'd3, 4'hF, 32'h1234_5678,  32'h0};
        tbl[7]  = '{3'd3, 4'h0, 32'h0,          32'h1234_5678};
        tbl[8]  = '{3'd1, 4'hF, 32'hFFFF_FFFF,  32'h0};
        tbl[9]  = '{3'd1, 4'h0, 32'h0,          32'h0000_FFFF};
        tbl[10] = '{3'd1, 4'hF, 32'h0,          32'h0000_FFFF};
        tbl[11] = '{3'd0, 4'hF, 32'hFFFF_FFF8,  32'h0};
        tbl[12] = '{3'd0, 4'h0, 32'h0,          32'h0};
        tbl[13] = '{3'd0, 4'hF, 32'h6,          32'h0};
        tbl[14] = '{3'd0, 4'h0, 32'h0,          32'h6};
        tbl[15] = '{3'd6, 4'hF, 32'hFFFF_FFFF,  32'h0};
        tbl[16] = '{3'd6, 4'h0, 32'h0,          32'h0};
        tbl[17] = '{3'd2, 4'hA, 32'hAABB_CCDD,  32'h0};
        tbl[18] = '{3'd2, 4'h0, 32'h0,          32'hAA00_CC00};
        tbl[19] = '{3'd0, 4'h1, 32'h0,          32'h6};
        tbl[20] = '{3'd0, 4'h0, 32'h0,          32'h0};
        tbl[21] = '{3'd2, 4'hF, 32'h0,          32'hAA00_CC00};
        for (int i = 0; i < 22; i++) begin
            acc(tbl[i].a, tbl[i].s, tbl[i].d, v);
            chk($sformatf("tbl[%0d]", i), v, tbl[i].exp);
        end

        // One-shot: tick every cycle, COUNT 3,2,1,0 then expiry and EN cleared.
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd2, 4'hF, 32'd3);
        wr(3'd0, 4'hF, 32'h5);
        rd(3'd2, v); chk("os_cnt2", v, 32'd2);
        rd(3'd2, v); chk("os_cnt0", v, 32'd0);
        chk("os_irq", {31'd0, bus.irq}, 32'd1);
        rd(3'd0, v); chk("os_ctrl", v, 32'h4);
        repeat (4) cyc();
        rd(3'd2, v); chk("os_cnt_hold", v, 32'd0);
        rd(3'd4, v); chk("os_exp", v, 32'd1);
        wr(3'd4, 4'h1, 32'd1);
        chk("os_irq_clr", {31'd0, bus.irq}, 32'd0);

        // Auto-reload: first tick 5 cycles after enable, then every 50 cycles.
        wr(3'd1, 4'hF, 32'd4);
        wr(3'd3, 4'hF, 32'd9);
        wr(3'd2, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'h3);
        repeat (2) cyc();
        rd(3'd4, v); chk("ar_exp_pre", v, 32'd0);
        rd(3'd4, v); chk("ar_exp_1st", v, 32'd1);
        rd(3'd2, v); chk("ar_reload", v, 32'd9);
        wr(3'd4, 4'hF, 32'd1);
        repeat (42) cyc();
        rd(3'd4, v); chk("ar_exp_gap", v, 32'd0);
        rd(3'd4, v); chk("ar_exp_2nd", v, 32'd1);
        rd(3'd2, v); chk("ar_reload2", v, 32'd9);
        chk("ar_irq", {31'd0, bus.irq}, 32'd0);
        wr(3'd0, 4'hF, 32'h0);

        // Held select: ready alternates, strobed bytes only.
        wr(3'd3, 4'hF, 32'd0);
        bus.sel = 1'b1; bus.addr = 3'd3; bus.wstrb = 4'b0101; bus.wdata = 32'hAABB_CCDD;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("hs_ready[%0d]", i), {31'd0, bus.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.sel = 1'b0; bus.wstrb = 4'b0;
        cyc();
        rd(3'd3, v); chk("hs_reload", v, 32'h00BB_00DD);

        // Clear vs expiry: RELOAD=0 with AUTO expires on every tick.
        wr(3'd3, 4'hF, 32'd0);
        wr(3'd2, 4'hF, 32'd0);
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'h7);
        wr(3'd4, 4'h1, 32'd1);
        chk("col_irq", {31'd0, bus.irq}, 32'd1);
        rd(3'd4, v); chk("col_exp", v, 32'd1);
        wr(3'd0, 4'hF, 32'h4);
        wr(3'd4, 4'h1, 32'd1);
        chk("col_irq_clr", {31'd0, bus.irq}, 32'd0);
        rd(3'd4, v); chk("col_exp_clr", v, 32'd0);

        // COUNT write lands on a tick edge (PRESCALE=1: ticks 2 and 4 edges after enable).
        wr(3'd1, 4'hF, 32'd1);
        wr(3'd2, 4'hF, 32'd50);
        wr(3'd0, 4'hF, 32'h1);
        wr(3'd2, 4'hF, 32'd100);
        rd(3'd2, v); chk("cw_count", v, 32'd100);
        wr(3'd0, 4'hF, 32'h0);

        // Async reset mid-access with irq high and ready high.
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd3, 4'hF, 32'd0);
        wr(3'd2, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'h7);
        bus.sel = 1'b1; bus.addr = 3'd0; bus.wstrb = 4'b0;
        cyc();
        chk("ar_pre_ready", {31'd0, bus.ready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, bus.ready}, 32'd0);
        chk("arst_irq",   {31'd0, bus.irq},   32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        model_reset();
        @(negedge clk);
        bus.sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("arst_no_ready", {31'd0, bus.ready}, 32'd0);
        end
        rd(3'd0, v); chk("arst_ctrl", v, 32'd0);
        rd(3'd2, v); chk("arst_count", v, 32'd0);

        // Random traffic against the model; small values keep the timer busy.
        for (int it = 0; it < 400; it++) begin
            repeat ($urandom_range(0, 3)) cyc();
            bus.addr  = 3'($urandom_range(0, 7));
            bus.wstrb = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
            case (bus.addr)
                3'd1:       bus.wdata = $urandom_range(0, 3);
                3'd2, 3'd3: bus.wdata = $urandom_range(0, 15);
                default:    bus.wdata = $urandom;
            endcase
            bus.sel = 1'b1;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 5) : 1;
            repeat (n) cyc();
            bus.sel = 1'b0; bus.wstrb = 4'b0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
